uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter sitting directly downstream of the single-cycle MIPS core's data-memory port, alongside data memory. It decodes core stores/loads to a 16-byte register window, buffers bytes in a small FIFO, and serialises them 8N1 on `txd` with a programmable baud divider. Reads are combinational so the core's same-cycle load path works unchanged.

---
 rtl/uart_tx_mmio.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory port: a 16-byte register window,
// a small TX FIFO and a programmable baud divider. Register reads are combinational.
module uart_tx_mmio #(
  parameter logic [31:0]      BASE_ADDR   = 32'hFFFF_0000,
  parameter int unsigned      FIFO_DEPTH  = 8,
  parameter int unsigned      DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           r_state, w_state_d;
  logic [7:0]       r_shift, w_shift_d;
  logic [2:0]       r_bit, w_bit_d;
  logic [DIV_W-1:0] r_baud, w_baud_d;
  logic [DIV_W-1:0] r_div;
  logic [AW:0]      r_wptr, r_rptr;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic             r_ovf, r_en, r_irqen, r_irq;

  logic             w_wr, w_full, w_empty, w_busy, w_pop, w_push_req, w_push, w_tick;
  logic [1:0]       w_off;
  logic [AW:0]      w_count;
  logic [31:0]      w_count32;
  logic [3:0]       w_cnt4;
  logic [DIV_W-1:0] w_div_m1;
  logic             w_unused;

  assign sel        = memaddr[31:4] == BASE_ADDR[31:4];
  assign w_wr       = memwrite & sel;
  assign w_off      = memaddr[3:2];
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty    = r_wptr == r_rptr;
  assign w_count    = r_wptr - r_rptr;
  assign w_count32  = 32'(w_count);
  assign w_cnt4     = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];
  assign w_busy     = r_state != StIdle;
  assign w_pop      = (r_state == StIdle) & r_en & ~w_empty;
  assign w_push_req = w_wr & (w_off == 2'd0);
  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_div_m1   = (r_div == '0) ? '0 : r_div - DIV_W'(1);
  assign w_tick     = r_baud == '0;
  assign irq        = r_irq;
  assign w_unused   = ^{memaddr[1:0], memwritedata};

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_bit_d   = r_bit;
    w_baud_d  = r_baud;
    unique case (r_state)
      StIdle: begin
        if (w_pop) begin
          w_state_d = StStart;
          w_shift_d = r_mem[r_rptr[AW-1:0]];
          w_bit_d   = 3'd0;
          w_baud_d  = w_div_m1;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_d = StData;
          w_baud_d  = w_div_m1;
        end else begin
          w_baud_d  = r_baud - DIV_W'(1);
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_d = r_shift >> 1;
          w_baud_d  = w_div_m1;
          if (r_bit == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_bit_d   = r_bit + 3'd1;
          end
        end else begin
          w_baud_d  = r_baud - DIV_W'(1);
        end
      end
      StStop: begin
        if (w_tick) begin
          w_state_d = StIdle;
        end else begin
          w_baud_d  = r_baud - DIV_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Decoded straight from the state register so reset forces the line high without a clock.
  always_comb begin
    unique case (r_state)
      StStart: txd = 1'b0;
      StData:  txd = r_shift[0];
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (w_off)
        2'd0: rdata = '0;
        2'd1: rdata = {24'b0, w_cnt4, r_ovf, w_busy, w_empty, w_full};
        2'd2: rdata = 32'(r_div);
        2'd3: rdata = {30'b0, r_irqen, r_en};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_div   <= DEFAULT_DIV;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 1'b1;
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_bit   <= w_bit_d;
      r_baud  <= w_baud_d;
      r_irq   <= r_irqen & w_empty & ~w_busy;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_wr && w_off == 2'd1 && memwritedata[3]) begin
        r_ovf <= 1'b0;
      end else if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (w_wr && w_off == 2'd2) r_div <= memwritedata[DIV_W-1:0];
      if (w_wr && w_off == 2'd3) begin
        r_en    <= memwritedata[0];
        r_irqen <= memwritedata[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= memwritedata[7:0];
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized self-checking bench for uart_tx_mmio: a queue-based FIFO model and an ideal 8N1
// waveform generator predict STATUS words and the txd line sample by sample.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
  localparam logic [31:0] A_CTRL = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = '0;
  logic [31:0] memwritedata = '0;
  logic        sel, txd, irq;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_w, obs_w;
  int           exp_pos;

  uart_tx_mmio dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .sel          (sel),
    .rdata        (rdata),
    .txd          (txd),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memaddr = a;
    memwritedata = d;
    memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a;
    #1;
    d = rdata;
  endtask

  function automatic logic [31:0] status_word(int cnt, bit ovf, bit busy, bit empty, bit full);
    int c;
    c = (cnt > 15) ? 15 : cnt;
    return {24'b0, 4'(c), ovf, busy, empty, full};
  endfunction

  task automatic model_clear();
    exp_w = '1;
    exp_pos = 0;
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_w[exp_pos] = 1'b1;
      exp_pos++;
    end
  endtask

  // Ideal frame: start, 8 data bits LSB first, stop; bits from index sb onward use divider db.
  task automatic model_frame(input logic [7:0] d, input int da, input int sb, input int db);
    logic b;
    int   len;
    for (int j = 0; j < 10; j++) begin
      b   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
      len = (j < sb) ? da : db;
      if (len == 0) len = 1;
      for (int i = 0; i < len; i++) begin
        exp_w[exp_pos] = b;
        exp_pos++;
      end
    end
  endtask

  // Caller is on the negedge after the triggering write edge; sample 0 is taken there.
  task automatic record(input int n);
    obs_w = '1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      obs_w[k] = txd;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", txd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    rd(A_STAT, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL reset_status got %h want 02", d); end
    rd(A_DIV, d);
    checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_div got %0d want 434", d); end
    rd(A_CTRL, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h want 1", d); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] a, d, v;
    a = $urandom & 32'h7FFF_FFFF;
    rd(a, d);
    checks++; if (sel !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL decode_outside sel %b rdata %h want 0 0", sel, d);
    end
    wr(a, $urandom);
    rd(A_STAT, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL decode_gated got %h want 02", d); end
    v = $urandom;
    wr(A_DIV, v);
    rd(A_DIV | 32'($urandom_range(0, 3)), d);
    checks++; if (sel !== 1'b1 || d !== {16'b0, v[15:0]}) begin
      errors++; $display("FAIL decode_div sel %b got %h want %h", sel, d, {16'b0, v[15:0]});
    end
  endtask

  task automatic test_single_byte();
    logic [7:0]  bytes [2];
    logic [31:0] d;
    bytes[0] = 8'hA5;
    bytes[1] = 8'($urandom);
    wr(A_CTRL, 32'h1);
    wr(A_DIV, 32'd4);
    foreach (bytes[b]) begin
      model_clear();
      model_idle(1);
      model_frame(bytes[b], 4, 10, 4);
      model_idle(3);
      wr(A_DATA, {24'($urandom), bytes[b]});
      obs_w = '1;
      for (int k = 0; k < exp_pos; k++) begin
        if (k > 0) @(negedge clk);
        obs_w[k] = txd;
        if (k == 0 || k == 6 || k == 40 || k == 41) begin
          rd(A_STAT, d);
          checks++;
          if (k == 0 && d !== status_word(1, 0, 0, 0, 0)) begin
            errors++; $display("FAIL single_status_push got %h want 10", d);
          end
          if ((k == 6 || k == 40) && d !== status_word(0, 0, 1, 1, 0)) begin
            errors++; $display("FAIL single_status_busy k=%0d got %h want 06", k, d);
          end
          if (k == 41 && d !== status_word(0, 0, 0, 1, 0)) begin
            errors++; $display("FAIL single_status_done got %h want 02", d);
          end
        end
      end
      checks++; if (obs_w !== exp_w) begin
        errors++; $display("FAIL single_wave byte %h got %h want %h", bytes[b], obs_w, exp_w);
      end
    end
  endtask

  // Fill the FIFO with en=0 (the model queue drops past depth 8), then enable and check the stream.
  task automatic fill_and_send(input string name, input int n, input int div, input bit chk_ovf);
    logic [7:0]  q[$];
    logic [7:0]  v;
    logic [31:0] d;
    bit          ovf;
    ovf = 1'b0;
    wr(A_DIV, 32'(div));
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < n; i++) begin
      v = 8'($urandom);
      wr(A_DATA, {24'($urandom), v});
      if (q.size() < 8) q.push_back(v);
      else ovf = 1'b1;
    end
    rd(A_STAT, d);
    checks++; if (d !== status_word(q.size(), ovf, 0, q.size() == 0, q.size() == 8)) begin
      errors++; $display("FAIL %s_status_filled got %h want %h", name, d,
                         status_word(q.size(), ovf, 0, q.size() == 0, q.size() == 8));
    end
    if (chk_ovf) begin
      wr(A_STAT, 32'h8);
      rd(A_STAT, d);
      checks++; if (d !== status_word(q.size(), 0, 0, 0, q.size() == 8)) begin
        errors++; $display("FAIL %s_ovf_clear got %h want %h", name, d,
                           status_word(q.size(), 0, 0, 0, q.size() == 8));
      end
    end
    model_clear();
    model_idle(1);
    foreach (q[i]) begin
      model_frame(q[i], div, 10, div);
      model_idle(1);
    end
    model_idle(2);
    wr(A_CTRL, 32'h1);
    record(exp_pos);
    checks++; if (obs_w !== exp_w) begin
      errors++; $display("FAIL %s_wave div %0d got %h want %h", name, div, obs_w, exp_w);
    end
    rd(A_STAT, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL %s_drained got %h want 02", name, d); end
  endtask

  task automatic test_overflow();
    fill_and_send("overflow", 9, 3, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_and_send("random", $urandom_range(1, 6), $urandom_range(0, 5), 1'b0);
    end
  endtask

  task automatic test_div_change();
    logic [7:0] v;
    v = 8'hFF;
    wr(A_DIV, 32'd4);
    wr(A_CTRL, 32'h1);
    model_clear();
    model_idle(1);
    model_frame(v, 4, 5, 2);
    model_idle(3);
    wr(A_DATA, {24'b0, v});
    obs_w = '1;
    for (int k = 0; k < exp_pos; k++) begin
      if (k > 0) @(negedge clk);
      obs_w[k] = txd;
      // Write lands on edge T+18, inside data bit 3 (edges T+17..T+21).
      if (k == 17) begin
        memaddr = A_DIV; memwritedata = 32'd2; memwrite = 1'b1;
      end
      if (k == 18) memwrite = 1'b0;
    end
    checks++; if (obs_w !== exp_w) begin
      errors++; $display("FAIL divchange_wave got %h want %h", obs_w, exp_w);
    end
  endtask

  task automatic test_irq();
    int k;
    wr(A_DIV, 32'd2);
    wr(A_CTRL, 32'h3);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle got %b want 1", irq); end
    wr(A_DATA, $urandom);
    wr(A_DATA, $urandom);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_busy got %b want 0", irq); end
    for (k = 3; k < 300; k++) begin
      @(negedge clk);
      if (irq === 1'b1) break;
    end
    checks++; if (k != 3 + 20 * 2) begin
      errors++; $display("FAIL irq_rise cycle got %0d want %0d", k, 3 + 20 * 2);
    end
    wr(A_CTRL, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_lag got %b want 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0]  v;
    logic [31:0] d;
    int          highs;
    v = 8'($urandom) & 8'hFB;
    wr(A_DIV, 32'd4);
    wr(A_CTRL, 32'h1);
    wr(A_DATA, {24'b0, v});
    repeat (14) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rstmid_bit2 got %b want 0", txd); end
    reset = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_async got %b want 1", txd); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(A_STAT, d);
    checks++; if (d !== 32'h02) begin errors++; $display("FAIL rstmid_status got %h want 02", d); end
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd === 1'b1) highs++;
    end
    checks++; if (highs != 60) begin errors++; $display("FAIL rstmid_quiet got %0d want 60", highs); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_single_byte();
    test_overflow();
    test_random();
    test_div_change();
    test_irq();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
